// File: rtl/spi_arbiter_pkg.sv
// spi_arbiter_pkg: shared state type and size constants
// for the SPI arbiter and its round-robin picker.
package spi_arbiter_pkg;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;
  localparam int DATA_W      = 32;
  localparam int WIDTH_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT_START,
    S_WAIT_END,
    S_RESP
  } state_t;
endpackage

// File: rtl/spi_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching
// upward from last+1 and wrapping at N-1 -> 0.
module rr_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic                 valid
);
  localparam int IW = $clog2(N);

  logic hit;
  int   pos;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    pos = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      if (!hit && req[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        hit = 1'b1;
      end
    end
  end

  assign valid = hit;
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI controller among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to enable the start timeout.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ           = NREQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ*DATA_W-1:0]    REQ_DIN,
  input  logic [NREQ*WIDTH_W-1:0]   REQ_MOSI_WIDTH,
  input  logic [NREQ*WIDTH_W-1:0]   REQ_MISO_WIDTH,
  output logic [NREQ-1:0]           REQ_ACCEPT,
  output logic [NREQ-1:0]           RSP_VALID,
  output logic [DATA_W-1:0]         RSP_DATA,
  output logic                      RSP_ERR,
  output logic                      SPI_KICK,
  input  logic                      SPI_BUSY,
  output logic [DATA_W-1:0]         SPI_DIN,
  output logic [WIDTH_W-1:0]        SPI_MOSI_WIDTH,
  output logic [WIDTH_W-1:0]        SPI_MISO_WIDTH,
  input  logic [DATA_W-1:0]         SPI_DOUT,
  input  logic                      SPI_DOUT_VALID,
  input  logic                      CS_IN,
  output logic [NREQ-1:0]           CS_OUT
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad
    $error("spi_arbiter: parameter out of range");
  end

  state_t              state, state_nx;
  logic [IW-1:0]       gidx, last_grant, win_idx;
  logic [NREQ-1:0]     win, gmask;
  logic                win_ok, grant, tmo, rsp_load;
  logic [DATA_W-1:0]   cap, din_q, rsp_q;
  logic [WIDTH_W-1:0]  mosi_q, miso_q;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (REQ_VALID),
    .last  (last_grant),
    .gnt   (win),
    .valid (win_ok)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = IW'(i);
  end

  assign grant    = (state == S_IDLE) && win_ok && !SPI_BUSY;
  assign rsp_load = (state == S_WAIT_END) && !SPI_BUSY;
  assign gmask    = NREQ'(1) << gidx;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  // counts from the KICK cycle so RESP lands TIMEOUT_CYCLES after it
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_KICK || state == S_WAIT_START) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo = (state == S_WAIT_START) && !SPI_BUSY &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) err_q <= 1'b0;
    else if (tmo) err_q <= 1'b1;
    else if (rsp_load) err_q <= 1'b0;
  end

  assign RSP_ERR = err_q;
`else
  assign tmo     = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:       if (grant) state_nx = S_KICK;
      S_KICK:       state_nx = S_WAIT_START;
      S_WAIT_START: begin
        if (SPI_BUSY) state_nx = S_WAIT_END;
        else if (tmo) state_nx = S_RESP;
      end
      S_WAIT_END:   if (!SPI_BUSY) state_nx = S_RESP;
      S_RESP:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gidx       <= '0;
      last_grant <= IW'(NREQ - 1);
      din_q      <= '0;
      mosi_q     <= '0;
      miso_q     <= '0;
      cap        <= '0;
      rsp_q      <= '0;
    end else begin
      if (grant) begin
        gidx   <= win_idx;
        din_q  <= REQ_DIN[int'(win_idx)*DATA_W +: DATA_W];
        mosi_q <= REQ_MOSI_WIDTH[int'(win_idx)*WIDTH_W +: WIDTH_W];
        miso_q <= REQ_MISO_WIDTH[int'(win_idx)*WIDTH_W +: WIDTH_W];
        cap    <= '0;
      end else if (state == S_WAIT_END && SPI_DOUT_VALID) begin
        cap <= SPI_DOUT;
      end
      // a word arriving on the same cycle BUSY drops still counts
      if (rsp_load)
        rsp_q <= SPI_DOUT_VALID ? SPI_DOUT : cap;
      else if (tmo)
        rsp_q <= '0;
      if (state == S_RESP) last_grant <= gidx;
    end
  end

  assign SPI_KICK       = (state == S_KICK);
  assign REQ_ACCEPT     = (state == S_KICK) ? gmask : '0;
  assign RSP_VALID      = (state == S_RESP) ? gmask : '0;
  assign RSP_DATA       = rsp_q;
  assign SPI_DIN        = din_q;
  assign SPI_MOSI_WIDTH = mosi_q;
  assign SPI_MISO_WIDTH = miso_q;

  always_comb begin
    CS_OUT = '1;
    if (state != S_IDLE) CS_OUT[gidx] = CS_IN;
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed self-checking bench for spi_arbiter
// with a hand-driven SPI controller model.
module tb_spi_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*32-1:0] req_din = '0;
  logic [N*8-1:0]  req_mosi_w = '0;
  logic [N*8-1:0]  req_miso_w = '0;
  logic [N-1:0]  req_accept, rsp_valid, cs_out;
  logic [31:0]   rsp_data, spi_din;
  logic          rsp_err, spi_kick;
  logic          spi_busy = 1'b0;
  logic [7:0]    spi_mosi_w, spi_miso_w;
  logic [31:0]   spi_dout = '0;
  logic          spi_dout_valid = 1'b0;
  logic          cs_in = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spi_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .REQ_VALID      (req_valid),
    .REQ_DIN        (req_din),
    .REQ_MOSI_WIDTH (req_mosi_w),
    .REQ_MISO_WIDTH (req_miso_w),
    .REQ_ACCEPT     (req_accept),
    .RSP_VALID      (rsp_valid),
    .RSP_DATA       (rsp_data),
    .RSP_ERR        (rsp_err),
    .SPI_KICK       (spi_kick),
    .SPI_BUSY       (spi_busy),
    .SPI_DIN        (spi_din),
    .SPI_MOSI_WIDTH (spi_mosi_w),
    .SPI_MISO_WIDTH (spi_miso_w),
    .SPI_DOUT       (spi_dout),
    .SPI_DOUT_VALID (spi_dout_valid),
    .CS_IN          (cs_in),
    .CS_OUT         (cs_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] d,
                         input logic [7:0] mw, input logic [7:0] sw);
    req_din[i*32 +: 32]  = d;
    req_mosi_w[i*8 +: 8] = mw;
    req_miso_w[i*8 +: 8] = sw;
  endtask

  // Waits for a kick, plays one transfer, checks the response.
  task automatic serve(input int g, input logic [31:0] din_exp,
                       input logic [31:0] dout, input bit give,
                       output int w, output int kcyc);
    logic [3:0]  m;
    logic [3:0]  csx;
    logic [31:0] exp_d;
    m = 4'(1 << g);
    csx = ~m;
    exp_d = give ? dout : 32'h0;
    w = 0;
    while (!spi_kick && w < 8) begin
      tick();
      w++;
    end
    chk("kick_seen", 32'(spi_kick), 32'd1);
    if (!spi_kick) return;
    kcyc = cyc;
    chk("accept", 32'(req_accept), 32'(m));
    chk("din_at_accept", spi_din, din_exp);
    tick();
    spi_busy = 1'b1;
    cs_in = 1'b0;
    tick();
    chk("cs_out_xfer", 32'(cs_out), 32'(csx));
    chk("din_at_busy", spi_din, din_exp);
    chk("kick_low", 32'(spi_kick), 32'd0);
    if (give) begin
      spi_dout = dout;
      spi_dout_valid = 1'b1;
    end
    tick();
    spi_dout_valid = 1'b0;
    spi_dout = 32'hFFFF_FFFF;
    repeat (2) tick();
    spi_busy = 1'b0;
    cs_in = 1'b1;
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'(m));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("rsp_once", 32'(rsp_valid), 32'd0);
    chk("rsp_hold", rsp_data, exp_d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int w, k1, k2, kicks, seen;
    w = 0; k1 = 0; k2 = 0; kicks = 0; seen = 0;

    req_valid = 4'b1111;
    set_req(0, 32'h1111_1111, 8'd32, 8'd32);
    repeat (3) tick();
    chk("rst_kick", 32'(spi_kick), 32'd0);
    chk("rst_accept", 32'(req_accept), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_spi_din", spi_din, 32'd0);
    chk("rst_mosi_w", 32'(spi_mosi_w), 32'd0);
    chk("rst_miso_w", 32'(spi_miso_w), 32'd0);
    chk("rst_cs_out", 32'(cs_out), 32'hF);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    set_req(2, 32'hA500_0000, 8'd8, 8'd8);
    req_valid = 4'b0100;
    serve(2, 32'hA500_0000, 32'h0000_003C, 1'b1, w, k1);
    chk("latency_single", 32'(w), 32'd1);
    req_valid = '0;
    tick();

    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 32'h1000_0000 + 32'(i), 8'd16, 8'd16);
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      serve(t % N, 32'h1000_0000 + 32'(t % N),
            32'h0000_0050 + 32'(t), 1'b1, w, k1);
      chk("rotate_latency", 32'(w), 32'd1);
    end
    req_valid = '0;
    tick();

    set_req(3, 32'h7700_0000, 8'd8, 8'd0);
    req_valid = 4'b1000;
    w = 0;
    while (!spi_kick && w < 8) begin
      tick();
      w++;
    end
    chk("miso0_width", 32'(spi_miso_w), 32'd0);
    serve(3, 32'h7700_0000, 32'h0, 1'b0, w, k1);
    req_valid = '0;
    tick();

    do_reset();
    set_req(1, 32'hC0DE_0001, 8'd8, 8'd8);
    req_valid = 4'b0010;
    w = 0;
    while (!spi_kick && w < 8) begin
      tick();
      w++;
    end
    chk("mid_kick", 32'(spi_kick), 32'd1);
    tick();
    spi_busy = 1'b1;
    cs_in = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cs", 32'(cs_out), 32'hF);
    chk("mid_rst_kick", 32'(spi_kick), 32'd0);
    tick();
    rst_n = 1'b1;
    kicks = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (spi_kick) kicks++;
    end
    chk("no_kick_while_busy", 32'(kicks), 32'd0);
    spi_busy = 1'b0;
    cs_in = 1'b1;
    serve(1, 32'hC0DE_0001, 32'h0000_00AB, 1'b1, w, k1);
    chk("kick_within_2", 32'(w >= 1 && w <= 2), 32'd1);
    req_valid = '0;
    tick();

    set_req(0, 32'hDEAD_BEEF, 8'd32, 8'd8);
    req_valid = 4'b0001;
    serve(0, 32'hDEAD_BEEF, 32'h0000_0011, 1'b1, w, k1);
    serve(0, 32'hDEAD_BEEF, 32'h0000_0022, 1'b1, w, k2);
    chk("b2b_kick_gap", 32'((k2 - k1 - 1) >= 2), 32'd1);
    req_valid = '0;
    tick();

    set_req(2, 32'h5555_0000, 8'd8, 8'd8);
    req_valid = 4'b0100;
    w = 0;
    while (!spi_kick && w < 8) begin
      tick();
      w++;
    end
    chk("tmo_kick", 32'(spi_kick), 32'd1);
    k1 = cyc;
    req_valid = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    w = 0;
    while (rsp_valid == '0 && w < 40) begin
      tick();
      w++;
    end
    chk("tmo_delay", 32'(cyc - k1), 32'(TMO));
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_rsp_data", rsp_data, 32'd0);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid != '0) seen++;
    end
    chk("no_tmo_rsp", 32'(seen), 32'd0);
    chk("no_tmo_err", 32'(rsp_err), 32'd0);
`endif
    do_reset();
    chk("final_cs", 32'(cs_out), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
